// File: rtl/exu_div_pkg.sv
// rtl/exu_div_pkg.sv - types and constants for the divider arbiter
`include "defines.svh"
package exu_div_pkg;
  localparam int DATA_W = `REG_DATA_WIDTH;
  localparam int ADDR_W = `REG_ADDR_WIDTH;
  localparam int CID_W  = `COMMIT_ID_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } div_arb_state_e;

  localparam logic [3:0] DIV_OP_DIV  = 4'b0001;
  localparam logic [3:0] DIV_OP_DIVU = 4'b0010;
  localparam logic [3:0] DIV_OP_REM  = 4'b0100;
  localparam logic [3:0] DIV_OP_REMU = 4'b1000;
endpackage

// File: rtl/defines.svh
// rtl/defines.svh - datapath widths shared by the EXU blocks
`ifndef EXU_DEFINES_SVH
`define EXU_DEFINES_SVH
`define REG_DATA_WIDTH 32
`define REG_ADDR_WIDTH 5
`define COMMIT_ID_WIDTH 3
`endif

// File: rtl/div_rr_arb2.sv
// rtl/div_rr_arb2.sv - two-way round-robin grant; pointer names the favoured lane
module div_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic [1:0] i_valid,
  output logic [1:0] o_gnt
);
  logic r_rr_ptr;

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      if (i_valid == 2'b11) o_gnt = r_rr_ptr ? 2'b10 : 2'b01;
      else                  o_gnt = i_valid;
    end
  end

  // After any grant the loser becomes favoured, so a lone requester cannot starve the other
  gnrl_dfflr #(.DW(1)) u_ptr (
    .clk(clk), .rst_n(rst_n), .lden(|o_gnt), .dnxt(o_gnt[0]), .qout(r_rr_ptr)
  );
endmodule

// File: rtl/gnrl_dfflr.sv
// rtl/gnrl_dfflr.sv - load-enabled flop with async active-low reset to zero
module gnrl_dfflr #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) qout <= '0;
    else if (lden) qout <= dnxt;
  end
endmodule

// File: rtl/exu_div_arb.sv
// rtl/exu_div_arb.sv - two-lane arbiter/sequencer for the shared divider
// Optional: DIV_ARB_ZERO_BYPASS_EN answers divide-by-zero without using the divider.
module exu_div_arb
  import exu_div_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              int_assert_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [3:0]        req0_op_i,
  input  logic [DATA_W-1:0] req0_dividend_i,
  input  logic [DATA_W-1:0] req0_divisor_i,
  input  logic [ADDR_W-1:0] req0_waddr_i,
  input  logic              req0_we_i,
  input  logic [CID_W-1:0]  req0_commit_id_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [3:0]        req1_op_i,
  input  logic [DATA_W-1:0] req1_dividend_i,
  input  logic [DATA_W-1:0] req1_divisor_i,
  input  logic [ADDR_W-1:0] req1_waddr_i,
  input  logic              req1_we_i,
  input  logic [CID_W-1:0]  req1_commit_id_i,
  output logic              div_start_o,
  output logic [DATA_W-1:0] div_dividend_o,
  output logic [DATA_W-1:0] div_divisor_o,
  output logic [3:0]        div_op_o,
  input  logic              div_busy_i,
  input  logic              div_valid_i,
  input  logic [DATA_W-1:0] div_result_i,
  input  logic              wb_ready_i,
  output logic              reg_we_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic [ADDR_W-1:0] reg_waddr_o,
  output logic [CID_W-1:0]  commit_id_o
);
  logic [1:0]        r_state;
  div_arb_state_e    w_state;
  div_arb_state_e    w_state_nxt;
  logic [1:0]        w_gnt;
  logic              w_gnt_en;
  logic              w_any_gnt;
  logic              w_sel1;
  logic [DATA_W-1:0] w_dividend;
  logic [DATA_W-1:0] w_divisor;
  logic [3:0]        w_op;
  logic [ADDR_W-1:0] w_waddr;
  logic              w_we;
  logic [CID_W-1:0]  w_cid;
  logic              w_bypass;
  logic              w_res_ld;
  logic [DATA_W-1:0] w_res_nxt;
  logic [ADDR_W-1:0] r_waddr;
  logic              r_we;
  logic [CID_W-1:0]  r_cid;
  logic [DATA_W-1:0] r_result;

  assign w_state  = div_arb_state_e'(r_state);
  assign w_gnt_en = (w_state == IDLE) && !div_busy_i && !int_assert_i;

  div_rr_arb2 u_arb (
    .clk(clk), .rst_n(rst_n), .i_en(w_gnt_en),
    .i_valid({req1_valid_i, req0_valid_i}), .o_gnt(w_gnt)
  );

  assign w_any_gnt  = |w_gnt;
  assign w_sel1     = w_gnt[1];
  assign w_dividend = w_sel1 ? req1_dividend_i  : req0_dividend_i;
  assign w_divisor  = w_sel1 ? req1_divisor_i   : req0_divisor_i;
  assign w_op       = w_sel1 ? req1_op_i        : req0_op_i;
  assign w_waddr    = w_sel1 ? req1_waddr_i     : req0_waddr_i;
  assign w_we       = w_sel1 ? req1_we_i        : req0_we_i;
  assign w_cid      = w_sel1 ? req1_commit_id_i : req0_commit_id_i;

`ifdef DIV_ARB_ZERO_BYPASS_EN
  // Quotient of x/0 is all-ones, remainder is x; both are known in the grant cycle
  assign w_bypass  = w_any_gnt && (w_divisor == '0);
  assign w_res_nxt = !w_bypass ? div_result_i :
                     ((w_op & (DIV_OP_DIV | DIV_OP_DIVU)) != 4'b0000) ? '1 : w_dividend;
`else
  assign w_bypass  = 1'b0;
  assign w_res_nxt = div_result_i;
`endif

  assign w_res_ld = ((w_state == RUN) && div_valid_i) || w_bypass;

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      IDLE:    if (w_any_gnt) w_state_nxt = w_bypass ? (w_we ? HOLD : IDLE) : RUN;
      RUN:     if (div_valid_i) w_state_nxt = r_we ? HOLD : IDLE;
      HOLD:    if (wb_ready_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  gnrl_dfflr #(.DW(2)) u_state (
    .clk(clk), .rst_n(rst_n), .lden(1'b1), .dnxt(w_state_nxt), .qout(r_state)
  );
  gnrl_dfflr #(.DW(ADDR_W)) u_waddr (
    .clk(clk), .rst_n(rst_n), .lden(w_any_gnt), .dnxt(w_waddr), .qout(r_waddr)
  );
  gnrl_dfflr #(.DW(1)) u_we (
    .clk(clk), .rst_n(rst_n), .lden(w_any_gnt), .dnxt(w_we), .qout(r_we)
  );
  gnrl_dfflr #(.DW(CID_W)) u_cid (
    .clk(clk), .rst_n(rst_n), .lden(w_any_gnt), .dnxt(w_cid), .qout(r_cid)
  );
  gnrl_dfflr #(.DW(DATA_W)) u_result (
    .clk(clk), .rst_n(rst_n), .lden(w_res_ld), .dnxt(w_res_nxt), .qout(r_result)
  );

  assign req0_ready_o   = w_gnt[0];
  assign req1_ready_o   = w_gnt[1];
  assign div_start_o    = w_any_gnt && !w_bypass;
  assign div_dividend_o = w_any_gnt ? w_dividend : '0;
  assign div_divisor_o  = w_any_gnt ? w_divisor  : '0;
  assign div_op_o       = w_any_gnt ? w_op       : 4'b0000;
  assign reg_we_o       = (w_state == HOLD);
  assign reg_wdata_o    = r_result;
  assign reg_waddr_o    = r_waddr;
  assign commit_id_o    = r_cid;
endmodule

// File: tb/tb_exu_div_arb.sv
// tb/tb_exu_div_arb.sv - scoreboard bench for exu_div_arb; bench acts as the divider
module tb_exu_div_arb;
  import exu_div_pkg::*;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic [CID_W-1:0]  cid;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              int_assert_i;
  logic              l_valid [2];
  logic [3:0]        l_op    [2];
  logic [DATA_W-1:0] l_a     [2];
  logic [DATA_W-1:0] l_b     [2];
  logic [ADDR_W-1:0] l_waddr [2];
  logic              l_we    [2];
  logic [CID_W-1:0]  l_cid   [2];
  logic              req0_ready_o, req1_ready_o;
  logic              div_start_o;
  logic [DATA_W-1:0] div_dividend_o, div_divisor_o;
  logic [3:0]        div_op_o;
  logic              div_busy_i, div_valid_i;
  logic [DATA_W-1:0] div_result_i;
  logic              wb_ready_i;
  logic              reg_we_o;
  logic [DATA_W-1:0] reg_wdata_o;
  logic [ADDR_W-1:0] reg_waddr_o;
  logic [CID_W-1:0]  commit_id_o;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  exu_div_arb dut (
    .clk(clk), .rst_n(rst_n), .int_assert_i(int_assert_i),
    .req0_valid_i(l_valid[0]), .req0_ready_o(req0_ready_o), .req0_op_i(l_op[0]),
    .req0_dividend_i(l_a[0]), .req0_divisor_i(l_b[0]), .req0_waddr_i(l_waddr[0]),
    .req0_we_i(l_we[0]), .req0_commit_id_i(l_cid[0]),
    .req1_valid_i(l_valid[1]), .req1_ready_o(req1_ready_o), .req1_op_i(l_op[1]),
    .req1_dividend_i(l_a[1]), .req1_divisor_i(l_b[1]), .req1_waddr_i(l_waddr[1]),
    .req1_we_i(l_we[1]), .req1_commit_id_i(l_cid[1]),
    .div_start_o(div_start_o), .div_dividend_o(div_dividend_o),
    .div_divisor_o(div_divisor_o), .div_op_o(div_op_o),
    .div_busy_i(div_busy_i), .div_valid_i(div_valid_i), .div_result_i(div_result_i),
    .wb_ready_i(wb_ready_i), .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o),
    .reg_waddr_o(reg_waddr_o), .commit_id_o(commit_id_o)
  );

  function automatic logic [DATA_W-1:0] ref_div(input logic [3:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    r = '0;
    if (op == DIV_OP_DIV)       r = (b == '0) ? '1 : DATA_W'($signed(a) / $signed(b));
    else if (op == DIV_OP_DIVU) r = (b == '0) ? '1 : a / b;
    else if (op == DIV_OP_REM)  r = (b == '0) ? a  : DATA_W'($signed(a) % $signed(b));
    else if (op == DIV_OP_REMU) r = (b == '0) ? a  : a % b;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int lane, input logic [3:0] op, input int a, input int b,
                          input int waddr, input logic we, input int cid);
    exp_t e;
    l_op[lane]    = op;
    l_a[lane]     = DATA_W'(a);
    l_b[lane]     = DATA_W'(b);
    l_waddr[lane] = ADDR_W'(waddr);
    l_we[lane]    = we;
    l_cid[lane]   = CID_W'(cid);
    l_valid[lane] = 1'b1;
    if (we) begin
      e.data = ref_div(op, DATA_W'(a), DATA_W'(b));
      e.addr = ADDR_W'(waddr);
      e.cid  = CID_W'(cid);
      sb.push_back(e);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // mode 0: winner drops valid; 1: winner reloads a new we=1 payload; 2: reloads with we=0
  task automatic run_op(input int exp_lane, input int lat, input int stall, input int mode,
                        input bit exp_hold, input bit irq_run, output int waited);
    bit                got;
    int                w;
    logic [3:0]        op;
    logic [DATA_W-1:0] a, b;
    exp_t              e;
    got = 0;
    waited = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (req0_ready_o || req1_ready_o) begin
        got = 1;
        waited = i;
        break;
      end
      tick();
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL grant_timeout: no ready within 16 cycles, required grant to lane %0d", exp_lane);
      return;
    end
    w = req1_ready_o ? 1 : 0;
    checks++;
    if (w !== exp_lane || (req0_ready_o && req1_ready_o)) begin
      errors++;
      $display("FAIL grant_lane: got ready0=%0b ready1=%0b, required lane %0d", req0_ready_o, req1_ready_o, exp_lane);
    end
    checks++;
    if (div_start_o !== 1'b1) begin
      errors++;
      $display("FAIL grant_start: div_start_o=%0b, required 1", div_start_o);
    end
    checks++;
    if (div_dividend_o !== l_a[w] || div_divisor_o !== l_b[w] || div_op_o !== l_op[w]) begin
      errors++;
      $display("FAIL operand_route: got %0d/%0d op %b, required %0d/%0d op %b",
               div_dividend_o, div_divisor_o, div_op_o, l_a[w], l_b[w], l_op[w]);
    end
    op = div_op_o;
    a  = div_dividend_o;
    b  = div_divisor_o;
    tick();
    case (mode)
      1: set_lane(w, l_op[w], int'(l_a[w]) + 3, int'(l_b[w]), int'(l_waddr[w]) + 1, 1'b1, int'(l_cid[w]) + 1);
      2: set_lane(w, l_op[w], int'(l_a[w]) + 5, int'(l_b[w]), int'(l_waddr[w]) + 1, 1'b0, int'(l_cid[w]) + 1);
      default: l_valid[w] = 1'b0;
    endcase
    div_busy_i = 1'b1;
    if (irq_run) int_assert_i = 1'b1;
    #1;
    checks++;
    if (req0_ready_o || req1_ready_o || div_start_o) begin
      errors++;
      $display("FAIL run_quiet: ready0=%0b ready1=%0b start=%0b, required all 0", req0_ready_o, req1_ready_o, div_start_o);
    end
    for (int k = 0; k < lat; k++) tick();
    div_valid_i  = 1'b1;
    div_result_i = ref_div(op, a, b);
    tick();
    div_valid_i  = 1'b0;
    div_result_i = '0;
    div_busy_i   = 1'b0;
    wb_ready_i   = (stall == 0);
    #1;
    checks++;
    if (reg_we_o !== exp_hold) begin
      errors++;
      $display("FAIL hold_entry: reg_we_o=%0b, required %0b", reg_we_o, exp_hold);
    end
    if (exp_hold) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: result produced with no expected entry, required an entry");
      end else begin
        e = sb.pop_front();
        if (reg_wdata_o !== e.data || reg_waddr_o !== e.addr || commit_id_o !== e.cid) begin
          errors++;
          $display("FAIL result: got data %0d waddr %0d cid %0d, required data %0d waddr %0d cid %0d",
                   reg_wdata_o, reg_waddr_o, commit_id_o, e.data, e.addr, e.cid);
        end
        for (int s = 0; s < stall; s++) begin
          tick();
          wb_ready_i = (s == stall - 1);
          #1;
          checks++;
          if (reg_we_o !== 1'b1 || reg_wdata_o !== e.data || reg_waddr_o !== e.addr ||
              commit_id_o !== e.cid || req0_ready_o || req1_ready_o) begin
            errors++;
            $display("FAIL hold_stable cycle %0d: we=%0b data=%0d waddr=%0d cid=%0d rdy=%0b%0b, required we=1 data=%0d waddr=%0d cid=%0d rdy=00",
                     s, reg_we_o, reg_wdata_o, reg_waddr_o, commit_id_o, req1_ready_o, req0_ready_o, e.data, e.addr, e.cid);
          end
        end
      end
    end
    tick();
    wb_ready_i   = 1'b0;
    int_assert_i = 1'b0;
    #1;
    checks++;
    if (reg_we_o !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle: reg_we_o=%0b, required 0", reg_we_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (req0_ready_o || req1_ready_o || div_start_o || reg_we_o) begin
      errors++;
      $display("FAIL reset_ctrl: rdy=%0b%0b start=%0b we=%0b, required all 0", req1_ready_o, req0_ready_o, div_start_o, reg_we_o);
    end
    checks++;
    if (reg_wdata_o !== '0 || reg_waddr_o !== '0 || commit_id_o !== '0) begin
      errors++;
      $display("FAIL reset_fields: data=%0d waddr=%0d cid=%0d, required 0", reg_wdata_o, reg_waddr_o, commit_id_o);
    end
    checks++;
    if (div_dividend_o !== '0 || div_divisor_o !== '0 || div_op_o !== 4'b0000) begin
      errors++;
      $display("FAIL reset_div_bus: %0d/%0d op %b, required 0", div_dividend_o, div_divisor_o, div_op_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int w;
    set_lane(0, DIV_OP_DIVU, 100, 7, 5, 1'b1, 3);
    run_op(0, 4, 0, 0, 1'b1, 1'b0, w);
    checks++;
    if (w !== 0) begin
      errors++;
      $display("FAIL single_latency: grant after %0d cycles, required 0", w);
    end
  endtask

  task automatic test_round_robin();
    int w;
    apply_reset();
    set_lane(0, DIV_OP_DIV, 50, 5, 1, 1'b1, 1);
    set_lane(1, DIV_OP_REMU, 50, 7, 2, 1'b1, 2);
    run_op(0, 2, 0, 1, 1'b1, 1'b0, w);
    run_op(1, 3, 0, 1, 1'b1, 1'b0, w);
    run_op(0, 1, 0, 2, 1'b1, 1'b0, w);
    run_op(1, 2, 0, 2, 1'b1, 1'b0, w);
    l_valid[0] = 1'b0;
    l_valid[1] = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rr_drain: %0d results outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int w;
    set_lane(0, DIV_OP_REM, 23, 5, 9, 1'b1, 7);
    set_lane(1, DIV_OP_DIVU, 81, 9, 10, 1'b1, 6);
    run_op(0, 2, 10, 0, 1'b1, 1'b0, w);
    run_op(1, 1, 0, 0, 1'b1, 1'b0, w);
    checks++;
    if (w !== 0) begin
      errors++;
      $display("FAIL next_grant: grant after %0d cycles in IDLE, required 0", w);
    end
  endtask

  task automatic test_interrupt_we();
    int w;
    int_assert_i = 1'b1;
    set_lane(1, DIV_OP_DIV, 90, 4, 12, 1'b1, 4);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (req1_ready_o || div_start_o) begin
        errors++;
        $display("FAIL irq_block: ready1=%0b start=%0b, required 0", req1_ready_o, div_start_o);
      end
      tick();
    end
    int_assert_i = 1'b0;
    run_op(1, 3, 0, 0, 1'b1, 1'b1, w);
    set_lane(0, DIV_OP_REMU, 30, 4, 13, 1'b0, 5);
    run_op(0, 2, 0, 0, 1'b0, 1'b0, w);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL we0_drain: %0d results outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid_op();
    l_op[0] = DIV_OP_DIVU; l_a[0] = 77; l_b[0] = 1; l_waddr[0] = 3; l_we[0] = 1'b1; l_cid[0] = 2;
    l_valid[0] = 1'b1;
    #1;
    checks++;
    if (req0_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_grant: ready0=%0b, required 1", req0_ready_o);
    end
    tick();
    l_valid[0] = 1'b0;
    div_busy_i = 1'b1;
    tick();
    div_valid_i = 1'b1;
    div_result_i = 77;
    tick();
    div_valid_i = 1'b0;
    div_busy_i = 1'b0;
    div_result_i = '0;
    #1;
    checks++;
    if (reg_we_o !== 1'b1 || reg_wdata_o !== 77) begin
      errors++;
      $display("FAIL mid_hold: we=%0b data=%0d, required we=1 data=77", reg_we_o, reg_wdata_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (reg_we_o !== 1'b0 || reg_wdata_o !== '0 || reg_waddr_o !== '0 || commit_id_o !== '0) begin
      errors++;
      $display("FAIL mid_reset: we=%0b data=%0d waddr=%0d cid=%0d, required all 0", reg_we_o, reg_wdata_o, reg_waddr_o, commit_id_o);
    end
    tick();
    rst_n = 1'b1;
    l_we[1] = 1'b0;
    l_valid[1] = 1'b1;
    #1;
    checks++;
    if (req1_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_idle: ready1=%0b after reset, required 1", req1_ready_o);
    end
    l_valid[1] = 1'b0;
  endtask

  task automatic test_zero_divisor();
    int w;
`ifdef DIV_ARB_ZERO_BYPASS_EN
    logic [3:0] ops [2];
    exp_t e;
    ops[0] = DIV_OP_DIV;
    ops[1] = DIV_OP_REM;
    w = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      set_lane(0, ops[i], 42, 0, 4 + i, 1'b1, 1 + i);
      #1;
      checks++;
      if (req0_ready_o !== 1'b1 || div_start_o !== 1'b0) begin
        errors++;
        $display("FAIL zb_grant: ready0=%0b start=%0b, required ready0=1 start=0", req0_ready_o, div_start_o);
      end
      tick();
      l_valid[0] = 1'b0;
      wb_ready_i = 1'b1;
      #1;
      checks++;
      if (reg_we_o !== 1'b1 || sb.size() == 0) begin
        errors++;
        $display("FAIL zb_hold: reg_we_o=%0b at T+1, required 1", reg_we_o);
      end else begin
        e = sb.pop_front();
        checks++;
        if (reg_wdata_o !== e.data || reg_waddr_o !== e.addr || commit_id_o !== e.cid) begin
          errors++;
          $display("FAIL zb_result: got data %0h waddr %0d cid %0d, required data %0h waddr %0d cid %0d",
                   reg_wdata_o, reg_waddr_o, commit_id_o, e.data, e.addr, e.cid);
        end
      end
      tick();
      wb_ready_i = 1'b0;
      #1;
      checks++;
      if (reg_we_o !== 1'b0) begin
        errors++;
        $display("FAIL zb_idle: reg_we_o=%0b, required 0", reg_we_o);
      end
    end
`else
    set_lane(0, DIV_OP_DIV, 42, 0, 4, 1'b1, 1);
    run_op(0, 2, 0, 0, 1'b1, 1'b0, w);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    int_assert_i = 1'b0;
    div_busy_i = 1'b0;
    div_valid_i = 1'b0;
    div_result_i = '0;
    wb_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      l_valid[i] = 1'b0; l_op[i] = 4'b0000; l_a[i] = '0; l_b[i] = '0;
      l_waddr[i] = '0; l_we[i] = 1'b0; l_cid[i] = '0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_interrupt_we();
    test_reset_mid_op();
    test_zero_divisor();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end
endmodule
